// File: rtl/irq_cp0_ctrl.sv
// irq_cp0_ctrl - coprocessor-0 style interrupt controller.
// Edge-detects three interrupt lines into pending bits, holds the
// disable (0x16), mask (0x17) and EPC (0x0e) registers, and redirects the
// ID-stage next PC on interrupt entry and on eret.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   irq_in        raw interrupt lines (synchronous to clk)
//   take_ok       ID stage holds a valid, unpaused, unflushed instruction
//   resume_pc     ID-stage next PC, saved to EPC on entry
//   eret          ID stage decodes eret
//   mtc0_we       ID stage mtc0 write strobe
//   cp0_addr      CP0 register number
//   cp0_wdata     mtc0 write data
//   cp0_rdata     mfc0 read data (combinational)
//   redirect      next-PC override this cycle (combinational)
//   redirect_pc   target PC when redirect=1, else 0
//   irq_pending   pending interrupt bits
//   in_handler    FSM is in HANDLER
module irq_cp0_ctrl #(
    parameter logic [31:0] ENTRY2 = 32'h0000_0400,
    parameter logic [31:0] ENTRY1 = 32'h0000_0600,
    parameter logic [31:0] ENTRY0 = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  irq_in,
    input  logic        take_ok,
    input  logic [31:0] resume_pc,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [2:0]  irq_pending,
    output logic        in_handler
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_HANDLER = 2'd2;

    localparam logic [4:0] A_EPC     = 5'h0e;
    localparam logic [4:0] A_DISABLE = 5'h16;
    localparam logic [4:0] A_MASK    = 5'h17;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_irq_prev;
    logic [2:0]  r_pending;
    logic        r_disable;
    logic [2:0]  r_mask;
    logic [31:0] r_epc;

    logic [2:0]  w_edge;
    logic [2:0]  w_req;
    logic [2:0]  w_sel;
    logic [31:0] w_entry_pc;
    logic        w_eret_go;
    logic        w_entry_go;
    logic        w_wr;

    assign w_edge    = irq_in & ~r_irq_prev;
    assign w_req     = r_pending & r_mask & {3{~r_disable}};
    assign w_eret_go = eret & take_ok;
    assign w_wr      = mtc0_we & take_ok;

    // Fixed priority select: line 2 highest, line 0 lowest.
    always_comb begin
        w_sel      = 3'b000;
        w_entry_pc = 32'h0;
        if (w_req[2]) begin
            w_sel      = 3'b100;
            w_entry_pc = ENTRY2;
        end else if (w_req[1]) begin
            w_sel      = 3'b010;
            w_entry_pc = ENTRY1;
        end else if (w_req[0]) begin
            w_sel      = 3'b001;
            w_entry_pc = ENTRY0;
        end
    end

    // Entry fires only from ARM; a concurrent eret takes the slot instead.
    assign w_entry_go = (r_state == S_ARM) && !w_eret_go && (w_req != 3'b000) && take_ok;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (w_eret_go) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_req != 3'b000) w_state_nxt = S_ARM;
                S_ARM: begin
                    if (w_req == 3'b000) w_state_nxt = S_IDLE;
                    else if (take_ok)    w_state_nxt = S_HANDLER;
                end
                S_HANDLER: w_state_nxt = S_HANDLER;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Edge detector and pending latch; a new edge wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_prev <= 3'b000;
            r_pending  <= 3'b000;
        end else begin
            r_irq_prev <= irq_in;
            r_pending  <= (r_pending & ~(w_entry_go ? w_sel : 3'b000)) | w_edge;
        end
    end

    // CP0 registers; entry and eret take precedence over mtc0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disable <= 1'b0;
            r_mask    <= 3'b000;
            r_epc     <= 32'h0;
        end else begin
            if (w_entry_go)                           r_disable <= 1'b1;
            else if (w_eret_go)                       r_disable <= 1'b0;
            else if (w_wr && cp0_addr == A_DISABLE)   r_disable <= cp0_wdata[0];

            if (w_wr && cp0_addr == A_MASK)           r_mask <= cp0_wdata[2:0];

            if (w_entry_go)                           r_epc <= resume_pc;
            else if (w_wr && cp0_addr == A_EPC)       r_epc <= cp0_wdata;
        end
    end

    // Redirect is combinational so it lands in the same ID cycle; held low in reset.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        if (!rst) begin
            if (w_eret_go) begin
                redirect    = 1'b1;
                redirect_pc = r_epc;
            end else if (w_entry_go) begin
                redirect    = 1'b1;
                redirect_pc = w_entry_pc;
            end
        end
    end

    // mfc0 read mux.
    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_addr)
            A_DISABLE: cp0_rdata = {31'b0, r_disable};
            A_MASK:    cp0_rdata = {29'b0, r_mask};
            A_EPC:     cp0_rdata = r_epc;
            default:   cp0_rdata = 32'h0;
        endcase
    end

    assign irq_pending = r_pending;
    assign in_handler  = (r_state == S_HANDLER);

endmodule
